// File: rtl/count_ctrl.sv
// Front-panel control for the counter: synchronizes and debounces run/clear buttons, then runs the IDLE/RUN/PAUSE/DONE machine.
// Optional COUNT_CTRL_AUTO_RESTART_EN: a run press in DONE restarts counting from zero.
module count_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int DB_W            = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_run,
    input  logic       btn_clr,
    input  logic       wrap_mode,
    input  logic       at_max,
    output logic       enable,
    output logic       clear,
    output logic       wrap,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic              clear_d;
    logic [1:0]        raw;
    logic [1:0]        s1;
    logic [1:0]        s2;
    logic [1:0]        db;
    logic [1:0]        press;
    logic [DB_W-1:0]   cnt [2];

    // Bit 0 is the run button, bit 1 the clear button.
    assign raw = {btn_clr, btn_run};

    // The press pulse is raised on the same edge db rises, so the FSM reacts one edge later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1    <= '0;
            s2    <= '0;
            db    <= '0;
            press <= '0;
            for (int i = 0; i < 2; i++) cnt[i] <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            for (int i = 0; i < 2; i++) begin
                press[i] <= 1'b0;
                if (s2[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    db[i]    <= s2[i];
                    cnt[i]   <= '0;
                    press[i] <= s2[i];
                end else begin
                    cnt[i] <= cnt[i] + DB_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            clear   <= 1'b0;
        end else begin
            state_q <= state_d;
            clear   <= clear_d;
        end
    end

    // A clear press overrides everything, including a simultaneous run press.
    always_comb begin
        state_d = state_q;
        clear_d = 1'b0;
        if (press[1]) begin
            state_d = IDLE;
            clear_d = 1'b1;
        end else begin
            case (state_q)
                IDLE:  if (press[0]) state_d = RUN;
                RUN: begin
                    if (press[0])
                        state_d = PAUSE;
                    else if (at_max && !wrap_mode)
                        state_d = DONE;
                end
                PAUSE: if (press[0]) state_d = RUN;
                DONE: begin
`ifdef COUNT_CTRL_AUTO_RESTART_EN
                    if (press[0]) begin
                        state_d = RUN;
                        clear_d = 1'b1;
                    end
`else
                    state_d = DONE;
`endif
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign enable = (state_q == RUN);
    assign wrap   = wrap_mode;
    assign state  = state_q;

endmodule

// File: tb/tb_count_ctrl.sv
// Self-checking bench for count_ctrl: directed scenarios followed by random button traffic,
// each cycle compared against a behavioural model of the panel.
module tb_count_ctrl;

    localparam int DC = 4;

    logic       tb_clk = 1'b0;
    logic       rst;
    logic       btn_run;
    logic       btn_clr;
    logic       wrap_mode;
    logic       at_max;
    logic       enable;
    logic       clear;
    logic       wrap;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;
    int clear_seen = 0;

    // Reference model: panel mode as a plain number, button history and debounce progress.
    int m_state;
    bit m_clear;
    bit m_press [2];
    bit m_db    [2];
    int m_run   [2];
    bit m_delay [2][2];

    count_ctrl dut (
        .clk       (tb_clk),
        .rst       (rst),
        .btn_run   (btn_run),
        .btn_clr   (btn_clr),
        .wrap_mode (wrap_mode),
        .at_max    (at_max),
        .enable    (enable),
        .clear     (clear),
        .wrap      (wrap),
        .state     (state)
    );

    always #5 tb_clk = ~tb_clk;

    task automatic model_reset();
        m_state = 0;
        m_clear = 1'b0;
        for (int b = 0; b < 2; b++) begin
            m_press[b]    = 1'b0;
            m_db[b]       = 1'b0;
            m_run[b]      = 0;
            m_delay[b][0] = 1'b0;
            m_delay[b][1] = 1'b0;
        end
    endtask

    // A button is seen two clocks late; its level is accepted once it has differed for DC clocks.
    task automatic model_step(input bit r_run, input bit r_clr);
        bit raw [2];
        bit seen;
        raw[0] = r_run;
        raw[1] = r_clr;
        m_clear = 1'b0;
        if (m_press[1]) begin
            m_state = 0;
            m_clear = 1'b1;
        end else if (m_press[0]) begin
            case (m_state)
                0:       m_state = 1;
                1:       m_state = 2;
                2:       m_state = 1;
                default: begin
`ifdef COUNT_CTRL_AUTO_RESTART_EN
                    m_state = 1;
                    m_clear = 1'b1;
`endif
                end
            endcase
        end else if (m_state == 1 && at_max && !wrap_mode) begin
            m_state = 3;
        end
        for (int b = 0; b < 2; b++) begin
            seen       = m_delay[b][1];
            m_press[b] = 1'b0;
            if (seen != m_db[b]) begin
                m_run[b]++;
                if (m_run[b] == DC) begin
                    m_db[b]    = seen;
                    m_run[b]   = 0;
                    m_press[b] = seen;
                end
            end else begin
                m_run[b] = 0;
            end
            m_delay[b][1] = m_delay[b][0];
            m_delay[b][0] = raw[b];
        end
    endtask

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_output();
        check_value("state", 32'(state), 32'(m_state));
        check_value("enable", 32'(enable), 32'(m_state == 1));
        check_value("clear", 32'(clear), 32'(m_clear));
        check_value("wrap", 32'(wrap), 32'(wrap_mode));
    endtask

    task automatic tick();
        @(posedge tb_clk);
        if (rst) model_reset();
        else     model_step(btn_run, btn_clr);
        #1;
        check_output();
        if (clear === 1'b1) clear_seen++;
    endtask

    task automatic apply_stimulus(input bit r_run, input bit r_clr, input int cycles);
        btn_run = r_run;
        btn_clr = r_clr;
        repeat (cycles) tick();
    endtask

    task automatic press_run();
        apply_stimulus(1'b1, 1'b0, 8);
        apply_stimulus(1'b0, 1'b0, 8);
    endtask

    task automatic press_clr();
        apply_stimulus(1'b0, 1'b1, 8);
        apply_stimulus(1'b0, 1'b0, 8);
    endtask

    initial begin
        rst       = 1'b1;
        btn_run   = 1'b1;
        btn_clr   = 1'b0;
        wrap_mode = 1'b0;
        at_max    = 1'b0;
        model_reset();
        $display("[TB] reset with run held");
        repeat (3) tick();
        check_value("reset_state", 32'(state), 32'd0);
        check_value("reset_enable", 32'(enable), 32'd0);
        check_value("reset_clear", 32'(clear), 32'd0);

        rst = 1'b0;
        repeat (7) tick();
        check_value("held_run_state", 32'(state), 32'd1);
        check_value("held_run_enable", 32'(enable), 32'd1);
        apply_stimulus(1'b0, 1'b0, 8);
        press_clr();
        check_value("clr_to_idle", 32'(state), 32'd0);

        $display("[TB] glitch reject");
        apply_stimulus(1'b1, 1'b0, 3);
        apply_stimulus(1'b0, 1'b0, 20);
        check_value("glitch_state", 32'(state), 32'd0);
        check_value("glitch_enable", 32'(enable), 32'd0);

        $display("[TB] run/pause");
        press_run();
        check_value("run1_state", 32'(state), 32'd1);
        press_run();
        check_value("pause_state", 32'(state), 32'd2);
        check_value("pause_enable", 32'(enable), 32'd0);
        press_run();
        check_value("run2_state", 32'(state), 32'd1);

        $display("[TB] clear priority");
        clear_seen = 0;
        apply_stimulus(1'b1, 1'b1, 8);
        apply_stimulus(1'b0, 1'b0, 8);
        check_value("prio_clear_count", 32'(clear_seen), 32'd1);
        check_value("prio_state", 32'(state), 32'd0);
        check_value("prio_enable", 32'(enable), 32'd0);

        $display("[TB] terminal stop");
        press_run();
        at_max = 1'b1;
        tick();
        check_value("done_state", 32'(state), 32'd3);
        check_value("done_enable", 32'(enable), 32'd0);
        at_max = 1'b0;
        tick();

        clear_seen = 0;
        press_run();
`ifdef COUNT_CTRL_AUTO_RESTART_EN
        check_value("restart_state", 32'(state), 32'd1);
        check_value("restart_clear_count", 32'(clear_seen), 32'd1);
`else
        check_value("done_hold_state", 32'(state), 32'd3);
        check_value("done_hold_clear_count", 32'(clear_seen), 32'd0);
`endif

        $display("[TB] wrap mode ignores at_max");
        press_clr();
        press_run();
        wrap_mode = 1'b1;
        at_max    = 1'b1;
        repeat (4) tick();
        check_value("wrap_state", 32'(state), 32'd1);
        check_value("wrap_out", 32'(wrap), 32'd1);
        at_max    = 1'b0;
        wrap_mode = 1'b0;
        tick();

        $display("[TB] random traffic");
        for (int seg = 0; seg < 70; seg++) begin
            if (seg == 35) begin
                rst = 1'b1;
                model_reset();
                repeat (2) tick();
                rst = 1'b0;
            end
            at_max = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 9) == 0) wrap_mode = ~wrap_mode;
            apply_stimulus(1'($urandom_range(0, 1)),
                           1'($urandom_range(0, 7) == 0),
                           int'($urandom_range(1, 9)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
